draw_req_scheduler: RTL and testbench
=====================================

Name: draw_req_scheduler

Overview:
- Shares one square-drawing engine (4x4 pixel block writer with go/done handshake) between NUM_REQ independent requesters, e.g. snake head draw, tail erase and food draw.
- Round-robin arbitrates pending requests, latches the winner's coordinate/colour, pulses go, and holds the operands stable until the engine reports done.
- Acknowledges the requester, with a watchdog against a hung engine.
- Sits between game logic and the square drawer, which feeds the VGA adapter.

Parameters:
- NUM_REQ, 3, number of requesters (2..8).
- TIMEOUT_CYCLES, 64, max cycles in WAIT_DONE before abort (must exceed the engine's worst-case 16-pixel draw plus overhead, about 20 cycles).
- IDX_W, $clog2(NUM_REQ), grant index width (derived).

Ports:
- CLOCK_50  in  1  system clock, rising edge.
- resetn  in  1  asynchronous active-low reset.
- req  in  NUM_REQ  per-requester request level; held high until ack.
- x_req  in  8*NUM_REQ  packed x origins; slice i = [8i+7:8i].
- y_req  in  7*NUM_REQ  packed y origins.
- c_req  in  3*NUM_REQ  packed colours.
- ack  out  NUM_REQ  one-hot, one-cycle completion pulse to the granted requester.
- go  out  1  one-cycle start pulse to the square drawer.
- x_out  out  8  latched x origin to the drawer.
- y_out  out  7  latched y origin.
- c_out  out  3  latched colour.
- sq_done  in  1  drawer completion pulse.
- busy  out  1  high in any state except IDLE.
- timeout_err  out  1  sticky; set on watchdog abort.
- clr_err  in  1  synchronous clear of timeout_err.

Behaviour:
- Reset (async, resetn=0): state=IDLE, ack=0, go=0, x_out=0, y_out=0, c_out=0, busy=0, timeout_err=0, RR pointer=0, watchdog=0. Reset mid-transaction abandons it silently: no ack is issued, and the drawer is reset by its own resetn.
- State machine, all outputs registered or decoded from the state register:
  - IDLE: if |req, grant g = first set bit of req searching from pointer upward with wrap. Latch x/y/c slice g into x_out/y_out/c_out and g into grant_idx, then go to ISSUE. Otherwise stay.
  - ISSUE: go=1 for exactly this one cycle; clear watchdog; go to WAIT_DONE.
  - WAIT_DONE: watchdog += 1 each cycle.
    - sq_done=1: go to ACK.
    - Else if watchdog == TIMEOUT_CYCLES-1: set timeout_err, go to ACK.
    - If both occur in the same cycle, done wins and no error is set.
  - ACK: ack[grant_idx]=1 for this cycle; pointer <= (grant_idx+1) mod NUM_REQ; go to IDLE.
- Latency:
  - req sampled high in IDLE at cycle t gives go at cycle t+1.
  - ack is asserted 1 cycle after the cycle in which sq_done is sampled.
  - Back-to-back minimum spacing between go pulses = drawer latency + 3 cycles.
- Operand stability: x_out/y_out/c_out change only on an IDLE grant; they hold from go through ack and after. The drawer latches one cycle after go, so this is mandatory.
- Requester rule:
  - req must be low in the cycle after its ack, otherwise it is treated as a new request.
  - Operand changes while req is pending but not yet granted are allowed; the values are sampled at the grant cycle.
  - Changes after the grant are ignored.
- sq_done is ignored in IDLE, ISSUE and ACK.
- clr_err clears timeout_err next edge. If clr_err and a new timeout coincide, the set wins.
- Fairness: with all requesters continuously requesting, grants rotate 0,1,2,0,… Any requester is served within NUM_REQ transactions.
- Widths: packed slices are selected by grant index. The pointer wrap uses explicit compare (NUM_REQ need not be a power of 2).

Decomposition:
- Shared package: state encoding (IDLE, ISSUE, WAIT_DONE, ACK), coordinate widths X_W=8, Y_W=7, C_W=3, shared with the drawer and the VGA adapter.
- Sub-module rr_arbiter (combinational): inputs req and pointer; outputs grant_valid and grant_idx. The scheduler FSM, operand registers and watchdog stay in the top module.

Test Plan:
- Reset: resetn=0 mid-WAIT_DONE. Required: all outputs 0 immediately (async); no ack after release; pointer=0.
- Single request: req=3'b010, x=8'd40, y=7'd20, c=3'b100; drawer model returns sq_done 18 cycles after go. Required: go 1 cycle after req; x_out=40, y_out=20, c_out=4 held stable through ack; ack=3'b010 exactly one cycle, 1 cycle after sq_done.
- Round-robin: req=3'b111 held, each requester dropping req after its own ack and re-raising 2 cycles later. Required: grant order 0,1,2,0,1,2; no requester granted twice in a row while others are pending.
- Operand capture: change x_req slice 0 from 10 to 99 one cycle after grant. Required: x_out stays 10 through ack.
- Timeout: drawer never asserts sq_done, TIMEOUT_CYCLES=64. Required: ack pulses 65 cycles after go (64 watchdog cycles plus ACK), timeout_err=1 and sticky; clr_err=1 clears it next cycle. Repeat with sq_done on the final watchdog cycle: required timeout_err stays 0.
- Spurious done: pulse sq_done in IDLE with req=0. Required: no state change, no ack, busy=0.

Source files
------------

// File: rtl/draw_req_scheduler_pkg.sv
// ----------------------------------------------------------------------------
// draw_req_scheduler_pkg
// Shared definitions for the square-drawing path: the scheduler FSM encoding
// and the coordinate/colour widths also used by the square drawer and the VGA
// adapter.
// Contents:
//   X_W, Y_W, C_W      : coordinate and colour widths (160x120 screen, 3-bit colour)
//   ST_*               : scheduler state encoding
//   draw_op_t          : one latched drawing operand (x, y, colour)
// ----------------------------------------------------------------------------
package draw_req_scheduler_pkg;

   localparam int X_W = 8;
   localparam int Y_W = 7;
   localparam int C_W = 3;

   localparam logic [1:0] ST_IDLE      = 2'd0;
   localparam logic [1:0] ST_ISSUE     = 2'd1;
   localparam logic [1:0] ST_WAIT_DONE = 2'd2;
   localparam logic [1:0] ST_ACK       = 2'd3;

   typedef struct packed {
      logic [X_W-1:0] x;
      logic [Y_W-1:0] y;
      logic [C_W-1:0] c;
   } draw_op_t;

endpackage

// File: rtl/draw_req_scheduler_if.sv
// ----------------------------------------------------------------------------
// draw_req_scheduler_if
// Bundles the requester-side and drawer-side signals of the draw request
// scheduler.
//   req/x_req/y_req/c_req : per-requester request level and packed operands
//   ack                   : one-hot completion pulse back to the requesters
//   go/x_out/y_out/c_out  : start pulse and latched operands to the drawer
//   sq_done               : drawer completion pulse
//   busy/timeout_err      : status; clr_err clears the sticky error
// Modports:
//   slave  : the scheduler itself
//   master : the environment (game logic + drawer) driving the scheduler
// ----------------------------------------------------------------------------
interface draw_req_scheduler_if #(
   parameter int NUM_REQ = 3
);
   import draw_req_scheduler_pkg::*;

   logic [NUM_REQ-1:0]     req;
   logic [X_W*NUM_REQ-1:0] x_req;
   logic [Y_W*NUM_REQ-1:0] y_req;
   logic [C_W*NUM_REQ-1:0] c_req;
   logic [NUM_REQ-1:0]     ack;
   logic                   go;
   logic [X_W-1:0]         x_out;
   logic [Y_W-1:0]         y_out;
   logic [C_W-1:0]         c_out;
   logic                   sq_done;
   logic                   busy;
   logic                   timeout_err;
   logic                   clr_err;

   modport slave (
      input  req, x_req, y_req, c_req, sq_done, clr_err,
      output ack, go, x_out, y_out, c_out, busy, timeout_err
   );

   modport master (
      output req, x_req, y_req, c_req, sq_done, clr_err,
      input  ack, go, x_out, y_out, c_out, busy, timeout_err
   );

endinterface

// File: rtl/draw_req_scheduler_rr_arbiter.sv
// ----------------------------------------------------------------------------
// draw_req_scheduler_rr_arbiter
// Combinational round-robin pick: the first set bit of i_req found by searching
// upward from i_ptr, wrapping past NUM_REQ-1 back to 0.
// Ports:
//   i_req         : request vector
//   i_ptr         : highest-priority index this round
//   o_grant_valid : any request present
//   o_grant_idx   : winning index (0 when nothing requested)
// ----------------------------------------------------------------------------
module draw_req_scheduler_rr_arbiter #(
   parameter int NUM_REQ = 3,
   parameter int IDX_W   = 2
) (
   input  logic [NUM_REQ-1:0] i_req,
   input  logic [IDX_W-1:0]   i_ptr,
   output logic               o_grant_valid,
   output logic [IDX_W-1:0]   o_grant_idx
);

   // One extra bit so ptr+offset (at most 2*NUM_REQ-2) never overflows.
   localparam int PW = IDX_W + 1;

   logic [PW-1:0]      w_sum     [NUM_REQ];
   logic [IDX_W-1:0]   w_rot_idx [NUM_REQ];
   logic [NUM_REQ-1:0] w_rot_req;

   // Rotate the request vector so position gi holds requester (ptr+gi) mod N.
   // Wrap is an explicit subtract because NUM_REQ need not be a power of 2.
   genvar gi;
   generate
      for (gi = 0; gi < NUM_REQ; gi++) begin : g_rot
         assign w_sum[gi]     = {1'b0, i_ptr} + PW'(gi);
         assign w_rot_idx[gi] = (w_sum[gi] >= PW'(NUM_REQ)) ?
                                IDX_W'(w_sum[gi] - PW'(NUM_REQ)) :
                                IDX_W'(w_sum[gi]);
         assign w_rot_req[gi] = i_req[w_rot_idx[gi]];
      end
   endgenerate

   assign o_grant_valid = |w_rot_req;

   // Lowest rotated position wins; scanning downward lets it overwrite last.
   always_comb begin
      o_grant_idx = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         if (w_rot_req[k]) begin
            o_grant_idx = w_rot_idx[k];
         end
      end
   end

endmodule

// File: rtl/draw_req_scheduler.sv
// ----------------------------------------------------------------------------
// draw_req_scheduler
// Shares one 4x4 square drawer between NUM_REQ requesters. Pending requests
// are round-robin arbitrated; the winner's operands are latched, the drawer is
// started with a one-cycle go, and the operands are held until the drawer
// reports done (or a watchdog gives up), after which the requester is acked.
// Ports:
//   CLOCK_50 : clock, rising edge
//   resetn   : asynchronous active-low reset
//   bus      : draw_req_scheduler_if.slave (request, operand, drawer and
//              status signals)
// Parameters:
//   NUM_REQ        : requester count (2..8)
//   TIMEOUT_CYCLES : WAIT_DONE cycles before the transaction is aborted
// ----------------------------------------------------------------------------
module draw_req_scheduler
   import draw_req_scheduler_pkg::*;
#(
   parameter int NUM_REQ        = 3,
   parameter int TIMEOUT_CYCLES = 64
) (
   input logic                 CLOCK_50,
   input logic                 resetn,
   draw_req_scheduler_if.slave bus
);

   localparam int IDX_W = $clog2(NUM_REQ);
   localparam int WD_W  = $clog2(TIMEOUT_CYCLES);

   logic [1:0]       r_state;
   logic [IDX_W-1:0] r_ptr;
   logic [IDX_W-1:0] r_grant_idx;
   draw_op_t         r_op;
   logic [WD_W-1:0]  r_wdog;
   logic             r_timeout_err;

   logic             w_grant_valid;
   logic [IDX_W-1:0] w_grant_idx;
   logic [IDX_W-1:0] w_ptr_next;
   logic             w_timeout;
   logic [NUM_REQ-1:0] w_ack;
   draw_op_t         w_op_slice [NUM_REQ];

   // Unpack the per-requester operand slices so the grant index can pick one.
   genvar gi;
   generate
      for (gi = 0; gi < NUM_REQ; gi++) begin : g_slice
         assign w_op_slice[gi] = {bus.x_req[gi*X_W +: X_W],
                                  bus.y_req[gi*Y_W +: Y_W],
                                  bus.c_req[gi*C_W +: C_W]};
      end
   endgenerate

   draw_req_scheduler_rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_arb (
      .i_req         (bus.req),
      .i_ptr         (r_ptr),
      .o_grant_valid (w_grant_valid),
      .o_grant_idx   (w_grant_idx)
   );

   assign w_ptr_next = (r_grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : r_grant_idx + 1'b1;

   // A done arriving on the last watchdog cycle still counts as success.
   assign w_timeout = (r_state == ST_WAIT_DONE) && !bus.sq_done &&
                      (r_wdog == WD_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         r_state       <= ST_IDLE;
         r_ptr         <= '0;
         r_grant_idx   <= '0;
         r_op          <= '0;
         r_wdog        <= '0;
         r_timeout_err <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               // Operands are sampled only here, so they stay frozen from go
               // through ack even if the requester changes them.
               if (w_grant_valid) begin
                  r_op        <= w_op_slice[w_grant_idx];
                  r_grant_idx <= w_grant_idx;
                  r_state     <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               r_wdog  <= '0;
               r_state <= ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
               r_wdog <= r_wdog + 1'b1;
               if (bus.sq_done || w_timeout) begin
                  r_state <= ST_ACK;
               end
            end
            default: begin
               r_ptr   <= w_ptr_next;
               r_state <= ST_IDLE;
            end
         endcase

         // Set takes priority over a simultaneous clear.
         if (w_timeout) begin
            r_timeout_err <= 1'b1;
         end else if (bus.clr_err) begin
            r_timeout_err <= 1'b0;
         end
      end
   end

   always_comb begin
      w_ack = '0;
      if (r_state == ST_ACK) begin
         w_ack[r_grant_idx] = 1'b1;
      end
   end

   assign bus.ack         = w_ack;
   assign bus.go          = (r_state == ST_ISSUE);
   assign bus.busy        = (r_state != ST_IDLE);
   assign bus.x_out       = r_op.x;
   assign bus.y_out       = r_op.y;
   assign bus.c_out       = r_op.c;
   assign bus.timeout_err = r_timeout_err;

endmodule

// File: tb/tb_draw_req_scheduler.sv
// ----------------------------------------------------------------------------
// tb_draw_req_scheduler
// Self-checking bench for draw_req_scheduler (NUM_REQ=3, TIMEOUT_CYCLES=64).
// Table-driven single transactions, hand-written reset/spurious-done cases,
// a deterministic round-robin run and a randomized run against a
// transaction-level reference model.
// ----------------------------------------------------------------------------
module tb_draw_req_scheduler;

   localparam int N  = 3;
   localparam int TO = 64;

   logic clk;
   logic resetn;

   draw_req_scheduler_if #(.NUM_REQ(N)) bus ();

   draw_req_scheduler #(
      .NUM_REQ        (N),
      .TIMEOUT_CYCLES (TO)
   ) u_dut (
      .CLOCK_50 (clk),
      .resetn   (resetn),
      .bus      (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      logic [2:0]  req;
      logic [23:0] x_req;
      logic [20:0] y_req;
      logic [8:0]  c_req;
      int          done_dly;   // cycles after go that sq_done pulses; -1 = never
      logic [2:0]  exp_ack;
      logic [7:0]  exp_x;
      logic [6:0]  exp_y;
      logic [2:0]  exp_c;
      int          exp_lat;    // go -> ack distance in cycles
      logic        exp_err;
   } vec_t;

   vec_t vecs [8];
   vec_t vrst;

   function automatic vec_t mk(input logic [2:0] req, input logic [23:0] x, input logic [20:0] y,
                               input logic [8:0] c, input int dd, input logic [2:0] ea,
                               input logic [7:0] ex, input logic [6:0] ey, input logic [2:0] ec,
                               input int lat, input logic err);
      vec_t v;
      v.req = req; v.x_req = x; v.y_req = y; v.c_req = c; v.done_dly = dd;
      v.exp_ack = ea; v.exp_x = ex; v.exp_y = ey; v.exp_c = ec; v.exp_lat = lat; v.exp_err = err;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         if (n_bad <= 40) $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      bus.req = '0; bus.x_req = '0; bus.y_req = '0; bus.c_req = '0;
      bus.sq_done = 1'b0; bus.clr_err = 1'b0;
   endtask

   task automatic do_reset();
      resetn = 1'b0;
      clear_inputs();
      repeat (3) tick();
      resetn = 1'b1;
   endtask

   // One complete transaction from IDLE; operands are scrambled after the grant.
   task automatic run_vec(input vec_t v, input int id);
      int         ack_at;
      logic [2:0] ack_val;
      logic       stable;
      logic       extra_go;
      bus.req = v.req; bus.x_req = v.x_req; bus.y_req = v.y_req; bus.c_req = v.c_req;
      bus.sq_done = 1'b0; bus.clr_err = 1'b0;
      tick();
      chk($sformatf("v%0d_go", id), 32'(bus.go), 32'd1);
      chk($sformatf("v%0d_x_out", id), 32'(bus.x_out), 32'(v.exp_x));
      chk($sformatf("v%0d_y_out", id), 32'(bus.y_out), 32'(v.exp_y));
      chk($sformatf("v%0d_c_out", id), 32'(bus.c_out), 32'(v.exp_c));
      ack_at = -1; ack_val = '0; stable = 1'b1; extra_go = 1'b0;
      for (int n = 1; n <= TO + 4 && ack_at < 0; n++) begin
         bus.x_req = ~v.x_req; bus.y_req = ~v.y_req; bus.c_req = ~v.c_req;
         bus.sq_done = (v.done_dly == n - 1);
         tick();
         if (bus.go) extra_go = 1'b1;
         if ({bus.x_out, bus.y_out, bus.c_out} !== {v.exp_x, v.exp_y, v.exp_c}) stable = 1'b0;
         if (bus.ack != 0) begin
            ack_at = n;
            ack_val = bus.ack;
         end
      end
      bus.req = '0; bus.sq_done = 1'b0;
      chk($sformatf("v%0d_ack_value", id), 32'(ack_val), 32'(v.exp_ack));
      chk($sformatf("v%0d_ack_latency", id), 32'(ack_at), 32'(v.exp_lat));
      chk($sformatf("v%0d_ops_stable", id), 32'(stable), 32'd1);
      chk($sformatf("v%0d_single_go", id), 32'(extra_go), 32'd0);
      chk($sformatf("v%0d_timeout_err", id), 32'(bus.timeout_err), 32'(v.exp_err));
      tick();
      chk($sformatf("v%0d_ack_one_cycle", id), 32'(bus.ack), 32'd0);
      chk($sformatf("v%0d_idle_busy", id), 32'(bus.busy), 32'd0);
      chk($sformatf("v%0d_ops_hold", id), 32'({bus.x_out, bus.y_out, bus.c_out}),
          32'({v.exp_x, v.exp_y, v.exp_c}));
      if (v.exp_err) begin
         chk($sformatf("v%0d_err_sticky", id), 32'(bus.timeout_err), 32'd1);
         bus.clr_err = 1'b1;
         tick();
         bus.clr_err = 1'b0;
         chk($sformatf("v%0d_err_cleared", id), 32'(bus.timeout_err), 32'd0);
      end
   endtask

   int glog [$];

   // Cycle-level environment with a transaction-level model: who wins is the
   // first pending requester from the model pointer, go follows an idle cycle
   // with any request, ack follows the done cycle (or go+65 on timeout).
   task automatic run_env(input bit rr, input int ncyc);
      int go_cyc, ack_cyc, done_cyc, to_cyc, m_ptr, exp_idx, d, r;
      int cool [N];
      logic [2:0] prev_req, cur_req, exp_ack;
      logic [23:0] prev_x, cur_x;
      logic [20:0] prev_y, cur_y;
      logic [8:0] prev_c, cur_c;
      logic prev_clr, cur_clr, cur_done, m_err, exp_go, idle_prev, exp_busy;
      logic [7:0] ex;
      logic [6:0] ey;
      logic [2:0] ec;
      glog.delete();
      do_reset();
      go_cyc = -1000; ack_cyc = -1000; done_cyc = -1; to_cyc = -1;
      m_ptr = 0; exp_idx = 0; m_err = 1'b0; ex = '0; ey = '0; ec = '0;
      for (int i = 0; i < N; i++) cool[i] = 0;
      cur_req = rr ? 3'b111 : 3'b000;
      cur_x = rr ? {8'd30, 8'd20, 8'd10} : 24'($urandom);
      cur_y = rr ? {7'd33, 7'd22, 7'd11} : 21'($urandom);
      cur_c = rr ? {3'd3, 3'd2, 3'd1} : 9'($urandom);
      cur_clr = 1'b0; cur_done = 1'b0;
      bus.req = cur_req; bus.x_req = cur_x; bus.y_req = cur_y; bus.c_req = cur_c;
      bus.sq_done = cur_done; bus.clr_err = cur_clr;
      prev_req = cur_req; prev_x = cur_x; prev_y = cur_y; prev_c = cur_c; prev_clr = cur_clr;
      for (int cyc = 1; cyc <= ncyc; cyc++) begin
         tick();
         idle_prev = !((cyc - 1) >= go_cyc && (cyc - 1) <= ack_cyc);
         if ((cyc - 1) == to_cyc) m_err = 1'b1;
         else if (prev_clr) m_err = 1'b0;
         exp_go = idle_prev && (prev_req != 0);
         if (exp_go) begin
            exp_idx = -1;
            for (int k = 0; k < N; k++)
               if (exp_idx < 0 && prev_req[(m_ptr + k) % N]) exp_idx = (m_ptr + k) % N;
            ex = prev_x[8*exp_idx +: 8];
            ey = prev_y[7*exp_idx +: 7];
            ec = prev_c[3*exp_idx +: 3];
            go_cyc = cyc;
            if (rr) d = 3;
            else begin
               r = int'($urandom % 10);
               d = (r == 0) ? -1 : (r == 1) ? 64 : 1 + int'($urandom % 25);
            end
            if (d < 0) begin
               done_cyc = -1; to_cyc = cyc + TO; ack_cyc = cyc + TO + 1;
            end else begin
               done_cyc = cyc + d; to_cyc = -1; ack_cyc = cyc + d + 1;
            end
         end
         exp_ack  = (cyc == ack_cyc) ? 3'(1 << exp_idx) : 3'b000;
         exp_busy = (cyc >= go_cyc && cyc <= ack_cyc);
         chk("env_go", 32'(bus.go), 32'(exp_go));
         chk("env_ack", 32'(bus.ack), 32'(exp_ack));
         chk("env_busy", 32'(bus.busy), 32'(exp_busy));
         chk("env_timeout_err", 32'(bus.timeout_err), 32'(m_err));
         chk("env_ops", 32'({bus.x_out, bus.y_out, bus.c_out}), 32'({ex, ey, ec}));
         if (cyc == ack_cyc) begin
            m_ptr = (exp_idx + 1) % N;
            glog.push_back(exp_idx);
         end
         for (int i = 0; i < N; i++) begin
            if (cyc == ack_cyc && i == exp_idx) begin
               cur_req[i] = 1'b0;
               cool[i] = rr ? 2 : 2 + int'($urandom % 4);
            end else if (!cur_req[i]) begin
               if (cool[i] > 0) cool[i]--;
               if (cool[i] == 0 && (rr || ($urandom % 3 == 0))) cur_req[i] = 1'b1;
            end
            if (!rr && ($urandom % 2 == 0)) begin
               cur_x[8*i +: 8] = 8'($urandom);
               cur_y[7*i +: 7] = 7'($urandom);
               cur_c[3*i +: 3] = 3'($urandom);
            end
         end
         cur_done = (cyc == done_cyc) ||
                    (!rr && !(cyc > go_cyc && cyc < ack_cyc) && ($urandom % 8 == 0));
         cur_clr  = !rr && (($urandom % 20 == 0) || (cyc == to_cyc && ($urandom % 2 == 0)));
         bus.req = cur_req; bus.x_req = cur_x; bus.y_req = cur_y; bus.c_req = cur_c;
         bus.sq_done = cur_done; bus.clr_err = cur_clr;
         prev_req = cur_req; prev_x = cur_x; prev_y = cur_y; prev_c = cur_c; prev_clr = cur_clr;
      end
      clear_inputs();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: simulation did not finish, expected end before %0t", $time);
      $fatal(1, "global timeout");
   end

   initial begin
      logic ack_any, busy_any;
      int   exp_rr [6];

      vecs[0] = mk(3'b010, {8'd7, 8'd40, 8'd3}, {7'd1, 7'd20, 7'd2}, {3'd1, 3'd4, 3'd2},
                   18, 3'b010, 8'd40, 7'd20, 3'd4, 19, 1'b0);
      vecs[1] = mk(3'b111, {8'd200, 8'd150, 8'd100}, {7'd90, 7'd60, 7'd30}, {3'd7, 3'd6, 3'd5},
                   5, 3'b100, 8'd200, 7'd90, 3'd7, 6, 1'b0);
      vecs[2] = mk(3'b011, {8'd1, 8'd2, 8'd10}, {7'd11, 7'd12, 7'd13}, {3'd3, 3'd2, 3'd1},
                   1, 3'b001, 8'd10, 7'd13, 3'd1, 2, 1'b0);
      vecs[3] = mk(3'b101, {8'd77, 8'd66, 8'd55}, {7'd44, 7'd33, 7'd22}, {3'd6, 3'd5, 3'd3},
                   -1, 3'b100, 8'd77, 7'd44, 3'd6, 65, 1'b1);
      vecs[4] = mk(3'b100, {8'd255, 8'd0, 8'd0}, {7'd127, 7'd0, 7'd0}, {3'd5, 3'd0, 3'd0},
                   64, 3'b100, 8'd255, 7'd127, 3'd5, 65, 1'b0);
      vecs[5] = mk(3'b001, {8'd9, 8'd8, 8'd129}, {7'd5, 7'd6, 7'd100}, {3'd2, 3'd3, 3'd7},
                   3, 3'b001, 8'd129, 7'd100, 3'd7, 4, 1'b0);
      vecs[6] = mk(3'b110, {8'd31, 8'd32, 8'd33}, {7'd41, 7'd42, 7'd43}, {3'd1, 3'd2, 3'd3},
                   2, 3'b010, 8'd32, 7'd42, 3'd2, 3, 1'b0);
      vecs[7] = mk(3'b011, {8'd50, 8'd51, 8'd52}, {7'd60, 7'd61, 7'd62}, {3'd4, 3'd5, 3'd6},
                   10, 3'b001, 8'd52, 7'd62, 3'd6, 11, 1'b0);
      vrst    = mk(3'b101, {8'd92, 8'd91, 8'd90}, {7'd72, 7'd71, 7'd70}, {3'd6, 3'd5, 3'd4},
                   2, 3'b001, 8'd90, 7'd70, 3'd4, 3, 1'b0);

      // Reset values.
      resetn = 1'b0;
      clear_inputs();
      repeat (3) tick();
      chk("reset_outputs", 32'({bus.go, bus.ack, bus.x_out, bus.y_out, bus.c_out}), 32'd0);
      chk("reset_busy", 32'(bus.busy), 32'd0);
      chk("reset_err", 32'(bus.timeout_err), 32'd0);
      resetn = 1'b1;
      tick();

      // Spurious done in IDLE with no request.
      bus.sq_done = 1'b1;
      tick();
      bus.sq_done = 1'b0;
      chk("spurious_busy", 32'(bus.busy), 32'd0);
      chk("spurious_ack_go", 32'({bus.ack, bus.go}), 32'd0);
      tick();
      chk("spurious_busy_later", 32'(bus.busy), 32'd0);
      chk("spurious_ack_go_later", 32'({bus.ack, bus.go}), 32'd0);

      for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

      // Reset in the middle of WAIT_DONE (pointer is 1 here).
      bus.req = 3'b010; bus.x_req = {8'd1, 8'd2, 8'd3}; bus.y_req = {7'd4, 7'd5, 7'd6};
      bus.c_req = {3'd7, 3'd6, 3'd5};
      tick();
      chk("rstmid_go", 32'(bus.go), 32'd1);
      repeat (5) tick();
      chk("rstmid_busy_before", 32'(bus.busy), 32'd1);
      #3;
      resetn = 1'b0;
      #1;
      chk("rstmid_async_outputs",
          32'({bus.go, bus.ack, bus.x_out, bus.y_out, bus.c_out, bus.busy, bus.timeout_err}), 32'd0);
      bus.req = '0;
      tick();
      tick();
      resetn = 1'b1;
      bus.sq_done = 1'b1;
      tick();
      bus.sq_done = 1'b0;
      ack_any = (bus.ack != 0);
      busy_any = bus.busy;
      for (int i = 0; i < 6; i++) begin
         tick();
         ack_any  = ack_any | (bus.ack != 0);
         busy_any = busy_any | bus.busy;
      end
      chk("rstmid_no_ack", 32'(ack_any), 32'd0);
      chk("rstmid_idle", 32'(busy_any), 32'd0);
      run_vec(vrst, 8);

      // Round-robin with all requesters busy.
      run_env(1'b1, 60);
      exp_rr = '{0, 1, 2, 0, 1, 2};
      chk("rr_grant_count_ge6", 32'(glog.size() >= 6), 32'd1);
      for (int i = 0; i < 6; i++)
         chk($sformatf("rr_grant_%0d", i), 32'((i < glog.size()) ? glog[i] : -1), 32'(exp_rr[i]));

      // Randomized traffic.
      run_env(1'b0, 3000);
      chk("rand_some_grants", 32'(glog.size() > 20), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
